// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the asynchronous SRAM controller.
// Optional feature macro: SRAM_PARITY_EN (adds one even-parity bit to the SRAM word).
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int WAIT_CNT_W = 4;

`ifdef SRAM_PARITY_EN
  localparam int PARITY_W = 1;
`else
  localparam int PARITY_W = 0;
`endif

  // Width of the SRAM data bus for a given processor data width.
  function automatic int dq_width(input int dw);
    return dw + PARITY_W;
  endfunction

  // Even parity bit: makes the total count of ones (data + bit) even.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram_ctrl_wait_cnt.sv
// Loadable down-counter that times the ACCESS phase; done when it reaches zero.
module sram_ctrl_wait_cnt
  import sram_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [WAIT_CNT_W-1:0] i_load_val,
  input  logic                  i_dec,
  output logic                  o_done
);

  logic [WAIT_CNT_W-1:0] r_cnt;

  // Load on entry to ACCESS, then count down once per ACCESS cycle, saturating at zero.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Single-request controller for an external asynchronous SRAM: SETUP, ACCESS
// (WAIT_STATES+1 cycles), HOLD, then a mandatory IDLE cycle for bus turnaround.
// All pad strobes are registered and derived from the next state.
// Optional feature macro: SRAM_PARITY_EN (even parity bit at the MSB of the SRAM word).
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_adr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  output logic                           rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_perr,
  output logic                           sram_ce_n,
  output logic                           sram_oe_n,
  output logic                           sram_we_n,
  output logic [ADDR_WIDTH-1:0]          sram_adr,
  output logic [DATA_WIDTH+PARITY_W-1:0] sram_dq_o,
  output logic                           sram_dq_oe,
  input  logic [DATA_WIDTH+PARITY_W-1:0] sram_dq_i
);

  localparam int DQW = dq_width(DATA_WIDTH);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_write;
  logic                  r_req_ready;
  logic                  r_ce_n;
  logic                  r_oe_n;
  logic                  r_we_n;
  logic                  r_dq_oe;
  logic                  r_rsp_valid;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DQW-1:0]        r_dq_o;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_accept;
  logic                  w_write_next;
  logic                  w_wait_done;
  logic                  w_last_access;
  logic [DQW-1:0]        w_dq_wr;

  // Ready is only ever high in IDLE, so a handshake always starts from IDLE.
  assign w_accept      = req_valid & r_req_ready;
  assign w_write_next  = w_accept ? req_write : r_write;
  assign w_last_access = (r_state == ST_ACCESS) & w_wait_done;

`ifdef SRAM_PARITY_EN
  assign w_dq_wr = {even_parity(64'(req_wdata)), req_wdata};
`else
  assign w_dq_wr = req_wdata;
`endif

  sram_ctrl_wait_cnt u_wait_cnt (
    .clk        (clk),
    .i_reset    (reset),
    .i_load     (r_state == ST_SETUP),
    .i_load_val (WAIT_CNT_W'(WAIT_STATES)),
    .i_dec      (r_state == ST_ACCESS),
    .o_done     (w_wait_done)
  );

  // Next-state logic for the access sequencer.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_next = ST_SETUP;
      ST_SETUP:  w_state_next = ST_ACCESS;
      ST_ACCESS: if (w_wait_done) w_state_next = ST_HOLD;
      ST_HOLD:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // State, registered strobes (decoded from next state) and request/response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_req_ready <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_adr       <= '0;
      r_dq_o      <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_write     <= w_write_next;
      r_req_ready <= (w_state_next == ST_IDLE);
      r_ce_n      <= (w_state_next == ST_IDLE);
      // Read drives oe_n through SETUP/ACCESS only; HOLD releases the bus early.
      r_oe_n      <= ~(~w_write_next & ((w_state_next == ST_SETUP) | (w_state_next == ST_ACCESS)));
      r_we_n      <= ~(w_write_next & (w_state_next == ST_ACCESS));
      r_dq_oe     <= w_write_next & ((w_state_next == ST_ACCESS) | (w_state_next == ST_HOLD));
      r_rsp_valid <= w_last_access;
      if (w_accept) begin
        r_adr <= req_adr;
        if (req_write) r_dq_o <= w_dq_wr;
      end
      if (w_last_access && !r_write) r_rdata <= sram_dq_i[DATA_WIDTH-1:0];
    end
  end

`ifdef SRAM_PARITY_EN
  logic r_perr;

  // Parity check of the read word, flagged together with the response pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_last_access & ~r_write &
                (even_parity(64'(sram_dq_i[DATA_WIDTH-1:0])) != sram_dq_i[DATA_WIDTH]);
    end
  end

  assign rsp_perr = r_perr;
`else
  assign rsp_perr = 1'b0;
`endif

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rdata;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_adr   = r_adr;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_dq_oe;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural async SRAM on the pads, reference memory model,
// per-cycle strobe timing derived from the access cycle table.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int W   = 1;
  localparam int DQW = DW + PARITY_W;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [AW-1:0]  req_adr;
  logic [DW-1:0]  req_wdata;
  logic           rsp_valid;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_perr;
  logic           sram_ce_n;
  logic           sram_oe_n;
  logic           sram_we_n;
  logic [AW-1:0]  sram_adr;
  logic [DQW-1:0] sram_dq_o;
  logic           sram_dq_oe;
  logic [DQW-1:0] sram_dq_i;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  bit            ref_wr  [0:(1<<AW)-1];
  bit            ref_bad [0:(1<<AW)-1];
  logic [DW-1:0] last_rdata;

  sram_ctrl #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .WAIT_STATES (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_adr    (req_adr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_perr   (rsp_perr),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_adr   (sram_adr),
    .sram_dq_o  (sram_dq_o),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_i  (sram_dq_i)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM.
  logic [DQW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DQW-1:0] w_flip;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_adr] <= sram_dq_o;
  end

`ifdef SRAM_PARITY_EN
  bit corrupt_en = 1'b0;
  assign w_flip = {corrupt_en && (sram_adr == 8'h10), {DW{1'b0}}};
`else
  assign w_flip = '0;
`endif

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? (sram_mem[sram_adr] ^ w_flip) : '0;

  function automatic logic [DQW-1:0] enc(input logic [DW-1:0] d);
`ifdef SRAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request; checks every cycle from accept (edge 0) to the following IDLE cycle.
  task automatic do_req(input bit wr, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                        input bit keep_valid);
    int n;
    bit exp_perr;
    logic [DW-1:0] exp_rd;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    check("ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_adr   = adr;
    req_wdata = wd;
    step();
    // inputs are free after acceptance
    req_valid = keep_valid;
    req_write = 1'($urandom);
    req_adr   = AW'($urandom);
    req_wdata = DW'($urandom);
    if (wr) begin
      ref_mem[adr] = wd;
      ref_wr[adr]  = 1'b1;
      ref_bad[adr] = 1'b0;
    end
`ifdef SRAM_PARITY_EN
    exp_perr = !wr && ref_bad[adr];
`else
    exp_perr = 1'b0;
`endif
    exp_rd = wr ? last_rdata : ref_mem[adr];
    for (int k = 1; k <= W + 4; k++) begin
      check("ce_n", 32'(sram_ce_n), 32'(!(k <= W + 3)));
      check("oe_n", 32'(sram_oe_n), 32'(!(!wr && k <= W + 2)));
      check("we_n", 32'(sram_we_n), 32'(!(wr && k >= 2 && k <= W + 2)));
      check("dq_oe", 32'(sram_dq_oe), 32'(wr && k >= 2 && k <= W + 3));
      check("bus_overlap", 32'(sram_dq_oe && !sram_oe_n), 32'd0);
      check("rsp_valid", 32'(rsp_valid), 32'(k == W + 3));
      check("req_ready", 32'(req_ready), 32'(k == W + 4));
      check("rsp_rdata", 32'(rsp_rdata), 32'((k >= W + 3) ? exp_rd : last_rdata));
      check("rsp_perr", 32'(rsp_perr), 32'(exp_perr && k == W + 3));
      if (k <= W + 3) check("sram_adr", 32'(sram_adr), 32'(adr));
      if (wr && k >= 2 && k <= W + 3) check("sram_dq_o", 32'(sram_dq_o), 32'(enc(wd)));
      if (k < W + 4) step();
    end
    last_rdata = exp_rd;
    $display("txn %s adr=%02h wdata=%04h rdata=%04h perr=%0b", wr ? "WR" : "RD", adr,
             wd, rsp_rdata, rsp_perr);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            wr;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_adr   = '0;
    req_wdata = '0;
    last_rdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ref_wr[i]  = 1'b0;
      ref_bad[i] = 1'b0;
    end

    // 1: reset values over three cycles, ready one cycle after release
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ce_n", 32'(sram_ce_n), 32'd1);
      check("rst_oe_n", 32'(sram_oe_n), 32'd1);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_perr", 32'(rsp_perr), 32'd0);
      check("rst_adr", 32'(sram_adr), 32'd0);
      check("rst_dq_o", 32'(sram_dq_o), 32'd0);
    end
    reset = 1'b0;
    step();
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // 2, 3: write then read back 0x2D
    do_req(1'b1, 8'h2D, 16'h002D, 1'b0);
    check("mem_2d", 32'(sram_mem[8'h2D]), 32'(enc(16'h002D)));
    do_req(1'b0, 8'h2D, 16'h0000, 1'b0);

    // 4: back-to-back read then write with valid held
    do_req(1'b0, 8'h2D, 16'h0000, 1'b1);
    do_req(1'b1, 8'h2E, 16'hBEEF, 1'b0);
    do_req(1'b0, 8'h2E, 16'h0000, 1'b0);

    // address extremes
    do_req(1'b1, 8'hFF, 16'h1234, 1'b0);
    do_req(1'b1, 8'h00, 16'h5678, 1'b0);
    do_req(1'b0, 8'hFF, 16'h0000, 1'b0);
    do_req(1'b0, 8'h00, 16'h0000, 1'b0);

    // 6: reset during ACCESS of a write aborts it without a response
    req_valid = 1'b1;
    req_write = 1'b1;
    req_adr   = 8'h10;
    req_wdata = 16'hA5A5;
    step();
    req_valid = 1'b0;
    step();
    check("abort_we_low", 32'(sram_we_n), 32'd0);
    reset = 1'b1;
    step();
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_ce_n", 32'(sram_ce_n), 32'd1);
    check("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    last_rdata = '0;
    ref_wr[8'h10] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      check("abort_idle_ce", 32'(sram_ce_n), 32'd1);
    end
    do_req(1'b1, 8'h10, 16'h00F0, 1'b0);

`ifdef SRAM_PARITY_EN
    corrupt_en = 1'b1;
    ref_bad[8'h10] = 1'b1;
    do_req(1'b0, 8'h10, 16'h0000, 1'b0);
    corrupt_en = 1'b0;
    ref_bad[8'h10] = 1'b0;
`endif
    do_req(1'b0, 8'h10, 16'h0000, 1'b0);

    // randomized traffic against the reference memory
    for (int i = 0; i < 24; i++) begin
      a  = ($urandom_range(0, 3) != 0) ? AW'($urandom_range(248, 255)) : AW'($urandom_range(0, 255));
      d  = DW'($urandom);
      wr = 1'($urandom);
      if (!wr && !ref_wr[a]) wr = 1'b1;
      do_req(wr, a, d, (i != 23) ? 1'($urandom) : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
